// File: rtl/tick_sched_pkg.sv
// Shared definitions for the tick scheduler: FSM state encoding and period limits.
package tick_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_PERIOD_1HZ = 125_000_000;
    localparam int MIN_PERIOD         = 2;

endpackage

// File: rtl/tick_downcounter.sv
// Loadable down-counter with a zero flag; load has priority over decrement.
module tick_downcounter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/tick_sched_ctrl.sv
// Programmable tick scheduler: periodic/one-shot single-cycle tick plus toggled clk_out.
// Optional sticky tick interrupt enabled by defining TICK_SCHED_CTRL_IRQ_EN.
module tick_sched_ctrl
    import tick_sched_pkg::*;
#(
    parameter int CNT_W          = 32,
    parameter int DEFAULT_PERIOD = DEFAULT_PERIOD_1HZ,
    parameter int TCNT_W         = 16
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              cfg_oneshot,
    output logic              cfg_err,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    output logic              tick,
    output logic              clk_out,
    output logic [TCNT_W-1:0] tick_count
`ifdef TICK_SCHED_CTRL_IRQ_EN
    ,
    output logic              irq,
    input  logic              irq_clr
`endif
);

    state_t           state;
    logic [CNT_W-1:0] period;
    logic             oneshot;

    logic             cnt_load;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_zero;

    // Counter reloads on start and on each periodic expiry; it holds at zero otherwise.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_en       = 1'b0;
        cnt_load_val = period - CNT_W'(1);
        if (state == IDLE) begin
            cnt_load = start && !stop && !cfg_valid;
        end else if (!stop) begin
            if (cnt_zero) begin
                cnt_load = !oneshot;
            end else begin
                cnt_en = 1'b1;
            end
        end
    end

    tick_downcounter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (clk_in),
        .rst      (rst),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state      <= IDLE;
            period     <= CNT_W'(DEFAULT_PERIOD);
            oneshot    <= 1'b0;
            tick       <= 1'b0;
            clk_out    <= 1'b0;
            busy       <= 1'b0;
            cfg_err    <= 1'b0;
            tick_count <= '0;
            cfg_ready  <= 1'b1;
        end else begin
            tick    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        if (cfg_period >= CNT_W'(MIN_PERIOD)) begin
                            period  <= cfg_period;
                            oneshot <= cfg_oneshot;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end else if (start && !stop) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        cfg_ready <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                    end else if (cnt_zero) begin
                        tick       <= 1'b1;
                        clk_out    <= !clk_out;
                        tick_count <= tick_count + TCNT_W'(1);
                        if (oneshot) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            cfg_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef TICK_SCHED_CTRL_IRQ_EN
    // Set has priority so a tick coinciding with a clear is never lost.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            irq <= 1'b0;
        end else if (tick) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/tick_sched_ctrl.md
Name: tick_sched_ctrl

Overview:
- Programmable tick scheduler and controller for the board's slow-clock domain.
- Replaces free-running derived clocks with a single-cycle clock-enable pulse (tick) plus an optional toggled square output (clk_out).
- Runs in periodic or one-shot mode; period is loaded through a valid/ready config handshake.
- Sits between the CPU/peripheral config logic and any slow-rate consumer: LED heartbeat, sensor sampling, wearable AI inference trigger.

Parameters:
- CNT_W, 32, width of period register and down-counter.
- DEFAULT_PERIOD, 125_000_000, period loaded at reset (1 s at 125 MHz).
- TCNT_W, 16, width of tick_count.

Ports:
- clk_in  input  1  125 MHz system clock.
- rst  input  1  synchronous, active-high reset.
- cfg_valid  input  1  config request.
- cfg_ready  output  1  config accepted this cycle when high with cfg_valid.
- cfg_period  input  CNT_W  cycles per tick; legal range 2..2^CNT_W-1.
- cfg_oneshot  input  1  1 = one-shot mode, 0 = periodic.
- cfg_err  output  1  1-cycle pulse when an illegal period is rejected.
- start  input  1  begin counting (level sampled per cycle).
- stop  input  1  abort counting.
- busy  output  1  high while in RUN.
- tick  output  1  registered 1-cycle enable pulse.
- clk_out  output  1  toggles on every tick (period 2P).
- tick_count  output  TCNT_W  ticks issued since reset; wraps.

Behaviour:
- Reset (rst=1 at a clk_in edge, synchronous), regardless of current state:
  - state=IDLE, period=DEFAULT_PERIOD, oneshot=0, counter=0.
  - tick=0, clk_out=0, busy=0, cfg_err=0, tick_count=0, cfg_ready=1.
- FSM states: IDLE, RUN.
- IDLE:
  - cfg_ready=1.
  - cfg_valid with cfg_period>=2: latch period and oneshot next cycle.
  - cfg_valid with cfg_period<2: cfg_err pulses next cycle; period and mode unchanged.
  - start=1 (no stop, no cfg_valid): counter<=period-1, go to RUN.
  - cfg_valid and start in the same cycle: config is taken first; start is ignored (must be reasserted).
- RUN:
  - busy=1, cfg_ready=0; cfg_valid is held off by the handshake, not dropped.
  - Counter decrements each cycle. When counter==0, the next cycle has tick=1, clk_out toggles, tick_count+1.
  - Periodic mode: counter reloads period-1 and RUN continues.
  - One-shot mode: return to IDLE.
- Timing: start sampled at cycle t → first tick at cycle t+P+1; periodic ticks then every P cycles exactly. For P=2: tick at t+3, t+5, ...
- stop=1 in RUN: IDLE next cycle, no tick issued even if counter==0 that same cycle. stop wins over start; stop in IDLE has no effect.
- start while in RUN is ignored (no restart).
- tick_count wraps from 2^TCNT_W-1 to 0 silently. clk_out holds its level across stop/start.
- Counter compare is at 0 only; no overflow possible because the loaded value is ≤ 2^CNT_W-2.

Optional Feature:
- Macro TICK_SCHED_CTRL_IRQ_EN.
- Defined: adds ports irq (output 1) and irq_clr (input 1).
  - irq is sticky and sets on every tick.
  - irq_clr clears it next cycle; set wins if tick and irq_clr coincide.
  - Reset value 0.
- Undefined: both ports and the logic are absent; all other behaviour is identical.

Decomposition:
- Package tick_sched_pkg holds:
  - state encoding (IDLE=1'b0, RUN=1'b1).
  - DEFAULT_PERIOD_1HZ=125_000_000 and MIN_PERIOD=2.
- One sub-module, tick_downcounter: loadable CNT_W down-counter with load, enable, and a zero flag.
- FSM, handshake, tick/clk_out/tick_count logic and IRQ stay in tick_sched_ctrl.

Test Plan:
- Reset with no config, start at cycle 10 (bench overrides DEFAULT_PERIOD=100) → first tick at cycle 111, then 211, 311; clk_out toggles at each tick; tick_count=3.
- Config P=5 periodic, start, run 50 cycles → 10 ticks exactly 5 cycles apart; busy stays 1; cfg_ready=0 throughout.
- Config P=1 → cfg_err pulses 1 cycle, period stays 5; config P=0 → same result.
- Config P=4 one-shot, start → single tick 5 cycles after start; busy drops the same cycle tick rises; no further ticks.
- P=8 periodic: assert stop in the exact cycle counter==0 → no tick; IDLE next cycle. Also drive start and stop together in IDLE → stays IDLE.
- Assert rst mid-RUN with tick_count=7 → next cycle all outputs at reset values; with IRQ_EN, irq=0; irq_clr coinciding with tick leaves irq=1.
